mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/edge_detect.sv | 32 +++
 rtl/mod_counter.sv | 111 +++++++++++
 tb/tb_mod_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default sizing for the modulo counter.
//   dir_e           : count direction (DIR_DOWN=0, DIR_UP=1)
//   DEFAULT_WIDTH   : default count width in bits
//   DEFAULT_MODULUS : default count sequence length
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned DEFAULT_WIDTH   = 3;
  localparam int unsigned DEFAULT_MODULUS = 8;

endpackage : counter_pkg

// File: rtl/edge_detect.sv
// Rising-edge detector with a synchronous active-low reset.
// Only instantiated when MOD_COUNTER_EDGE_EN is defined.
//   clk   : clock
//   rst_n : synchronous active-low reset; clears the history register
//   d     : level input
//   rise  : high for the cycle in which d=1 and the previous sampled d was 0
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  // History always tracks d, so an edge is consumed even if the consumer ignores it.
  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule : edge_detect

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with clear, load, wrap-or-saturate and a sticky overflow flag.
// Build option: define MOD_COUNTER_EDGE_EN to step once per rising edge of en instead of on
// every cycle en is high.
//   clk      : clock, all state updates on the rising edge
//   rst_n    : synchronous active-low reset (overrides everything)
//   en       : step request
//   up       : 1 = increment, 0 = decrement
//   clr      : clear count and ovf
//   load     : load load_val (clamped to MODULUS-1)
//   load_val : value to load
//   count    : registered count, 0..MODULUS-1
//   tc       : one-cycle pulse after a boundary step (wrap or saturate)
//   ovf      : sticky flag set by any boundary step
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MODULUS  = DEFAULT_MODULUS,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // 64-bit compare so WIDTH=32 does not overflow the range check.
  if ((WIDTH < 2) || (WIDTH > 32) || (MODULUS < 2) ||
      (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_param_check
    $error("mod_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  dir_e             dir;

  assign dir = dir_e'(up);

`ifdef MOD_COUNTER_EDGE_EN
  logic en_rise;

  edge_detect u_edge_detect (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (en),
    .rise (en_rise)
  );

  assign step = en_rise;
`else
  assign step = en;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        // Explicit compare against MaxVal; never rely on the natural 2**WIDTH wrap.
        if (count_q == MaxVal) begin
          count_d = SATURATE ? count_q : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SATURATE ? count_q : MaxVal;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter. Three instances share one stimulus stream:
//   0: WIDTH=3 MODULUS=6 wrap, 1: WIDTH=3 MODULUS=6 saturate, 2: WIDTH=3 MODULUS=8 wrap.
// Each is compared every cycle against an arithmetic reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, clr, load;
  logic [2:0] load_val;
  logic [2:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int errors = 0;
  int checks = 0;

  int mod_of [3] = '{6, 6, 8};
  int sat_of [3] = '{0, 1, 0};
  int m_cnt  [3];
  int m_tc   [3];
  int m_ovf  [3];
  int en_prev;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) u_dut_wrap6 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) u_dut_sat6 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_dut_wrap8 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: position on a ring of mod_of[i] slots; leaving the ring is a boundary event.
  task automatic model_edge();
    int step;
    int nxt;
`ifdef MOD_COUNTER_EDGE_EN
    step = (en && !en_prev) ? 1 : 0;
`else
    step = en ? 1 : 0;
`endif
    en_prev = rst_n ? int'(en) : 0;
    for (int i = 0; i < 3; i++) begin
      m_tc[i] = 0;
      if (!rst_n) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) < mod_of[i]) ? int'(load_val) : mod_of[i] - 1;
      end else if (step != 0) begin
        nxt = m_cnt[i] + (up ? 1 : -1);
        if (nxt < 0 || nxt >= mod_of[i]) begin
          m_tc[i]  = 1;
          m_ovf[i] = 1;
          if (sat_of[i] == 0) m_cnt[i] = (nxt + mod_of[i]) % mod_of[i];
        end else begin
          m_cnt[i] = nxt;
        end
      end
    end
  endtask

  // Advance one clock, update the model at the edge, compare everything 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("tc[%0d]", i), int'(tc_o[i]), m_tc[i]);
      check($sformatf("ovf[%0d]", i), int'(ovf_o[i]), m_ovf[i]);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic c,
                       input logic l, input logic [2:0] v);
    rst_n = r; en = e; up = u; clr = c; load = l; load_val = v;
  endtask

  int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    en_prev = 0;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end

    // Reset overrides en and load.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    tick();
    tick();
    check("reset_count", int'(cnt_o[0]), 0);
    check("reset_ovf", int'(ovf_o[0]), 0);

    // Seven up steps on the MODULUS=6 wrap instance.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
`ifndef MOD_COUNTER_EDGE_EN
      check("up7_count", int'(cnt_o[0]), exp_seq[k]);
      check("up7_tc", int'(tc_o[0]), (k == 5) ? 1 : 0);
      check("up7_ovf", int'(ovf_o[0]), (k >= 5) ? 1 : 0);
`endif
    end

    // Saturating down from 0 holds and pulses tc each step.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
`ifndef MOD_COUNTER_EDGE_EN
      check("sat_down_count", int'(cnt_o[1]), 0);
      check("sat_down_tc", int'(tc_o[1]), 1);
      check("sat_down_ovf", int'(ovf_o[1]), 1);
`endif
    end

    // Load clamps, leaves ovf alone; clr beats load.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    tick();
    check("load_clamp6", int'(cnt_o[0]), 5);
    check("load_full8", int'(cnt_o[2]), 7);
    check("load_tc", int'(tc_o[0]), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    tick();
    check("clr_wins", int'(cnt_o[0]), 0);
    check("clr_ovf", int'(ovf_o[0]), 0);

    // Reset at count=4 with en and load active.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    tick();
    check("load4", int'(cnt_o[0]), 4);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    check("midreset_count", int'(cnt_o[0]), 0);
    check("midreset_tc", int'(tc_o[0]), 0);
    check("midreset_ovf", int'(ovf_o[0]), 0);

    // Full-range MODULUS=8: down from 0 wraps to 7, up from 7 wraps to 0.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    check("m8_down_count", int'(cnt_o[2]), 7);
    check("m8_down_tc", int'(tc_o[2]), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    check("m8_up_count", int'(cnt_o[2]), 0);
    check("m8_up_tc", int'(tc_o[2]), 1);

    // en held high 10 cycles, then three 0/1 toggles.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 10; k++) tick();
`ifdef MOD_COUNTER_EDGE_EN
    check("edge_hold", int'(cnt_o[2]), 1);
`endif
    for (int k = 0; k < 3; k++) begin
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
    end
`ifdef MOD_COUNTER_EDGE_EN
    check("edge_toggle", int'(cnt_o[2]), 4);
`endif

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(31) != 0), $urandom_range(1), $urandom_range(1),
            ($urandom_range(15) == 0), ($urandom_range(7) == 0), 3'($urandom_range(7)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mod_counter
